// File: rtl/pe_acc.sv
// pe_acc: reduction and accumulation stage behind the int16 multiplier array.
// Each beat carries LANES signed products. The beat is reduced through a
// registered adder tree (S1: LANES -> LANES/8 partials, S2: partials -> one
// beat sum). The beat sums are then accumulated over a group closed by in_last
// (S3). The stage emits one signed sum per group on a valid/ready output with
// full back-pressure.
// Optional build macro: PE_ACC_SAT_EN clamps each emitted result to the int32
// range and reports the clamp on out_sat. The internal accumulator is never
// clamped.
module pe_acc #(
  parameter int LANES  = 32,
  parameter int PROD_W = 32,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES*PROD_W-1:0] mult_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    out_sat
);

  localparam int NPART = LANES / 8;

  logic                    stall;
  logic                    accept;

  logic signed [ACC_W-1:0] lvl0 [LANES];
  logic signed [ACC_W-1:0] lvl1 [LANES/2];
  logic signed [ACC_W-1:0] lvl2 [LANES/4];
  logic signed [ACC_W-1:0] lvl3 [NPART];

  logic                    v1_q, last1_q;
  logic signed [ACC_W-1:0] part_q [NPART];

  logic                    v2_q, last2_q;
  logic signed [ACC_W-1:0] beat_sum_d, beat_sum_q;

  logic signed [ACC_W-1:0] acc_q, acc_next_d, res_d;
  logic [CNT_W-1:0]        cnt_q, cnt_next_d;
  logic                    first_q, sat_d;
  logic                    out_valid_q, out_sat_q;
  logic [ACC_W-1:0]        out_sum_q;
  logic [CNT_W-1:0]        out_beats_q;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;
  assign out_sat   = out_sat_q;

  // Sign-extend every lane, then run three adder levels down to NPART partials
  always_comb begin
    for (int i = 0; i < LANES; i++)
      lvl0[i] = {{(ACC_W-PROD_W){mult_result[PROD_W*i+PROD_W-1]}},
                 mult_result[PROD_W*i +: PROD_W]};
    for (int i = 0; i < LANES/2; i++) lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
    for (int i = 0; i < LANES/4; i++) lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    for (int i = 0; i < NPART; i++)   lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
  end

  // S1 register: partials plus beat valid/last; frozen while the output stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      for (int i = 0; i < NPART; i++) part_q[i] <= '0;
    end else if (!stall) begin
      v1_q    <= accept;
      last1_q <= in_last;
      if (accept)
        for (int i = 0; i < NPART; i++) part_q[i] <= lvl3[i];
    end
  end

  // Final reduction of the partials into one beat sum
  always_comb begin
    beat_sum_d = '0;
    for (int i = 0; i < NPART; i++) beat_sum_d = beat_sum_d + part_q[i];
  end

  // S2 register: beat sum with its valid/last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q       <= 1'b0;
      last2_q    <= 1'b0;
      beat_sum_q <= '0;
    end else if (!stall) begin
      v2_q       <= v1_q;
      last2_q    <= last1_q;
      beat_sum_q <= beat_sum_d;
    end
  end

  // Next accumulator/count; the first beat of a group restarts from zero
  always_comb begin
    acc_next_d = (first_q ? '0 : acc_q) + beat_sum_q;
    cnt_next_d = first_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
  end

  // Result value presented at group close, optionally clamped to int32
  always_comb begin
    res_d = acc_next_d;
    sat_d = 1'b0;
`ifdef PE_ACC_SAT_EN
    if (acc_next_d > $signed({{(ACC_W-31){1'b0}}, {31{1'b1}}})) begin
      res_d = $signed({{(ACC_W-31){1'b0}}, {31{1'b1}}});
      sat_d = 1'b1;
    end else if (acc_next_d < $signed({{(ACC_W-31){1'b1}}, {31{1'b0}}})) begin
      res_d = $signed({{(ACC_W-31){1'b1}}, {31{1'b0}}});
      sat_d = 1'b1;
    end
`endif
  end

  // S3: accumulate beats, load the result at group close, run the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (v2_q) begin
        if (last2_q) begin
          out_sum_q   <= res_d;
          out_beats_q <= cnt_next_d;
          out_sat_q   <= sat_d;
          out_valid_q <= 1'b1;
          first_q     <= 1'b1;
        end else begin
          acc_q   <= acc_next_d;
          cnt_q   <= cnt_next_d;
          first_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_acc.sv
// Scoreboard bench for pe_acc: stimulus pushes hand-computed group results,
// and a negedge monitor pops and compares on every output handshake.
module tb_pe_acc;
  localparam int LANES  = 32;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 48;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid, in_ready, in_last;
  logic [LANES*PROD_W-1:0] mult_result;
  logic                    out_valid, out_ready, out_sat;
  logic [ACC_W-1:0]        out_sum;
  logic [CNT_W-1:0]        out_beats;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] beats;
    logic             sat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pe_acc #(.LANES(LANES), .PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .mult_result(mult_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_beats(out_beats), .out_sat(out_sat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input longint sum, input int beats, input bit sat);
    exp_t e;
    e.sum   = ACC_W'(sum);
    e.beats = CNT_W'(beats);
    e.sat   = sat;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat is taken
  task automatic send(input logic [PROD_W-1:0] lane, input logic last);
    int n = 0;
    in_valid    = 1'b1;
    in_last     = last;
    mult_result = {LANES{lane}};
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL out_valid_timeout: out_valid stayed 0, expected 1");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake consumes exactly one scoreboard entry
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got out_sum 0x%0h, expected no result", out_sum);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_sum",   out_sum,   mon_e.sum);
        check("out_beats", out_beats, mon_e.beats);
        check("out_sat",   out_sat,   mon_e.sat);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    mult_result = '0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_out_beats", out_beats, 0);
    check("rst_out_sat",   out_sat,   0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single beat, latency T+3
    expect_res(32, 1, 0);
    send(32'h1, 1'b1);
    @(negedge clk); check("lat_t1_valid", out_valid, 0);
    @(negedge clk); check("lat_t2_valid", out_valid, 0);
    @(negedge clk); check("lat_t3_valid", out_valid, 1);
    wait_drain();

    // Three-beat group with a bubble inside and a negative beat
    expect_res(544, 3, 0);
    send(32'h2, 1'b0);
    @(posedge clk); #1;
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h10, 1'b1);
    wait_drain();

    // Back-pressure: result held for 5 cycles while a second group streams
    out_ready = 1'b0;
    expect_res(160, 1, 0);
    expect_res(192, 3, 0);
    fork
      begin
        send(32'h5, 1'b1);
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h3, 1'b1);
      end
      begin
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
          check("bp_in_ready",  in_ready,  0);
          check("bp_hold_sum",  out_sum,   160);
          check("bp_hold_beat", out_beats, 1);
          if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Back-to-back single-beat groups: out_valid must never drop
    expect_res(32, 1, 0);
    expect_res(64, 1, 0);
    expect_res(96, 1, 0);
    expect_res(-128, 1, 0);
    expect_res(8192, 1, 0);
    expect_res(1048544, 1, 0);
    fork
      begin
        send(32'h1, 1'b1);
        send(32'h2, 1'b1);
        send(32'h3, 1'b1);
        send(32'hFFFF_FFFC, 1'b1);
        send(32'h100, 1'b1);
        send(32'h7FFF, 1'b1);
      end
      begin
        wait_out_valid();
        for (int i = 0; i < 6; i++) begin
          check("b2b_out_valid", out_valid, 1);
          if (i < 5) @(negedge clk);
        end
      end
    join
    wait_drain();

    // Extremes: 4 beats of int32 max in every lane
`ifdef PE_ACC_SAT_EN
    expect_res(64'd2147483647, 4, 1);
`else
    expect_res(64'd274877906816, 4, 0);
`endif
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h7FFF_FFFF, 1'b1);
    wait_drain();

    // Reset mid-group: partial sum discarded, outputs clear asynchronously
    send(32'h7, 1'b0);
    send(32'h7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_sum",   out_sum,   0);
    check("mrst_out_beats", out_beats, 0);
    check("mrst_in_ready",  in_ready,  1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_res(96, 1, 0);
    send(32'h3, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_acc.md
Name: pe_acc

Overview:
- Downstream stage of the int16 multiplier array in the matrix PE.
- Consumes one 1024-bit beat of 32 signed int32 products per cycle.
- Reduces each beat through a registered adder tree, then accumulates beats over a dot-product group delimited by in_last.
- Emits one signed sum per group on a valid/ready output, with full back-pressure.

Parameters:
- LANES, 32, number of signed products per beat.
- PROD_W, 32, width of each product lane.
- ACC_W, 48, accumulator and output width; must be ≥ PROD_W+$clog2(LANES)+1.
- CNT_W, 16, width of the per-group beat counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  beat present on mult_result.
- in_ready  out  1  stage can accept a beat this cycle.
- in_last  in  1  beat is the final beat of its group.
- mult_result  in  LANES*PROD_W  packed products; lane i at [PROD_W*i+PROD_W-1 : PROD_W*i], two's complement.
- out_valid  out  1  group result held.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  signed group sum.
- out_beats  out  CNT_W  number of beats in the group.
- out_sat  out  1  saturation occurred (only meaningful with the optional feature).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All valid flags, the accumulator, the beat counter, out_sum, out_beats and out_sat clear to 0. in_ready is 1 one cycle after rst_n rises.
- Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - Every pipeline register, the accumulator and the counter hold while stall=1.
- Accept: a beat is accepted when in_valid & in_ready.
- Stage S1 (registered):
  - Each product is sign-extended to ACC_W.
  - Three combinational adder levels reduce 32 lanes to 4 partials.
  - Registered with v1 and last1.
- Stage S2 (registered): the 4 partials reduce to 1 beat sum, registered with v2 and last2.
- Stage S3 (accumulate), when v2 & ~stall:
  - acc_next = (first ? 0 : acc) + beat_sum.
  - cnt_next = (first ? 1 : cnt+1).
  - If last2: out_sum <= acc_next, out_beats <= cnt_next, out_valid <= 1, first <= 1.
  - Otherwise: acc <= acc_next, cnt <= cnt_next, first <= 0.
- Output handshake:
  - out_valid clears on out_valid & out_ready unless a new last2 completes in the same cycle, in which case it stays 1 and the new result is loaded.
  - out_sum, out_beats and out_sat are stable while out_valid & ~out_ready.
- Latency: accepted last beat at cycle T gives out_valid=1 at T+3. Throughput is 1 beat/cycle with no stall.
- Arithmetic: all additions are signed at ACC_W. Overflow of ACC_W wraps modulo 2^ACC_W; no flag is raised.
- Counter: wraps modulo 2^CNT_W.
- Single-beat group: in_last=1 on the first beat gives out_beats=1.
- Bubbles: in_valid gaps inside a group are allowed; the accumulator holds.
- Reset mid-group: partial accumulation is discarded and the next accepted beat starts a new group.

Optional Feature:
- Macro: PE_ACC_SAT_EN.
- Defined:
  - At result load, acc_next is clamped to [-2^31, 2^31-1] and sign-extended into out_sum.
  - out_sat=1 if clamping changed the value, else 0.
  - Internal accumulation stays unclamped at ACC_W.
- Undefined: out_sum = acc_next unmodified and out_sat is tied to 0.

Test Plan:
- Reset then one beat: all lanes 0x00000001, in_last=1, out_ready=1 -> out_valid at T+3 with out_sum=32, out_beats=1.
- Three-beat group:
  - Lanes = 0x00000002, then 0xFFFFFFFF (-1), then 0x00000010.
  - Expect out_sum = 64 - 32 + 512 = 544 and out_beats = 3.
- Back-pressure: hold out_ready=0 for 5 cycles with a result pending and a second group streaming.
  - in_ready=0 during the hold.
  - Nothing is lost.
  - The second result appears after the first handshake.
- Back-to-back single-beat groups every cycle with out_ready=1:
  - out_valid stays 1 continuously.
  - Successive out_sum values match each beat's sum.
- Extremes over 4 beats, all lanes 0x7FFFFFFF:
  - out_sum = 128*(2^31-1) = 274877906816.
  - With PE_ACC_SAT_EN: out_sum=2147483647 and out_sat=1.
- Reset mid-group: drop rst_n after 2 beats of a 4-beat group.
  - Outputs clear asynchronously.
  - A following 1-beat group of lanes=0x00000003 gives out_sum=96, out_beats=1.
